slot_payout_ctrl: RTL
=====================

Name: slot_payout_ctrl

Overview:
- Downstream of the three reel channels (counter, random-value register and comparator per reel).
- Gates each play against a credit balance and issues the spin grant.
- Waits until all three reel comparators report stopped, classifies the final reel symbols into a win code, then pays credits out one per tick.
- Credits, win code and status go to the display/LED logic.

Parameters:
- CREDIT_W, 8: width of the credit balance.
- START_CREDITS, 10: balance loaded at reset.
- BET, 1: credits deducted per granted spin.
- PAY_PAIR, 2: payout when exactly two reels match.
- PAY_TRIPLE, 10: payout when all three reels match (non-jackpot symbol).
- PAY_JACKPOT, 50: payout when all three reels show JACKPOT_SYM.
- JACKPOT_SYM, 4'h7: jackpot reel symbol.
- START_TMO, 3: ticks to wait in WAIT_START for any reel to begin running.
- SETTLE, 2: consecutive CLK cycles with reel_run==3'b000 required before a stop is accepted.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- CLR  in  1  synchronous active-high reset.
- reel1  in  4  final symbol of reel 1.
- reel2  in  4  final symbol of reel 2.
- reel3  in  4  final symbol of reel 3.
- reel_run  in  3  per-reel comparator enables; 1 = reel still spinning. Combinational, may glitch.
- spin_req  in  1  single-cycle debounced play request.
- tick  in  1  single-cycle pacing strobe (1 Hz domain, synchronised to CLK).
- spin_go  out  1  single-cycle spin grant to the reel registers.
- credits  out  CREDIT_W  current balance.
- win_code  out  2  0 none, 1 pair, 2 triple, 3 jackpot; valid from EVAL until the next grant.
- busy  out  1  high in every state except IDLE.
- paying  out  1  high in PAYOUT.
- no_credit  out  1  combinational: credits < BET.

Behaviour:
- Reset (CLR=1 on a posedge):
  - state=IDLE, credits=START_CREDITS, win_code=0, spin_go=0.
  - Timeout counter, settle counter and remaining-pay register cleared.
  - Reset wins over every other event and aborts any state; an in-progress payout is lost.
- IDLE:
  - spin_req && credits>=BET: credits -= BET, spin_go=1 for exactly one cycle (the cycle after the request edge), win_code=0, timeout counter=0, go to WAIT_START.
  - spin_req && credits<BET: ignored; stay in IDLE, credits unchanged.
- WAIT_START:
  - Any reel_run bit high: go to SPIN.
  - Else each tick increments the timeout counter; on reaching START_TMO go to SPIN. This covers the case where the latched values already equal the reel positions.
- SPIN:
  - Settle counter increments each cycle reel_run==0 and clears on any nonzero cycle.
  - When it reaches SETTLE, go to EVAL.
  - A stop shorter than SETTLE cycles is a glitch and is ignored.
- EVAL (one cycle): register win_code and the remaining-pay amount, then go to PAYOUT.
  - r1==r2==r3==JACKPOT_SYM: code 3, PAY_JACKPOT.
  - Else r1==r2==r3: code 2, PAY_TRIPLE.
  - Else any pair equal: code 1, PAY_PAIR.
  - Else: code 0, pay 0.
- PAYOUT:
  - Each tick while remaining>0: credits += 1 (saturating at 2^CREDIT_W-1), remaining -= 1.
  - When remaining==0, return to IDLE on the same cycle the check is made. Pay 0 spends exactly one cycle in PAYOUT.
  - Saturation does not stop the countdown; excess credits are discarded.
- spin_req outside IDLE is dropped, not queued.
- tick outside WAIT_START/PAYOUT has no effect.
- win_code holds its value in IDLE until the next grant clears it.
- All arithmetic is unsigned CREDIT_W bits; pay constants are truncated to CREDIT_W.
- Deduction of BET never underflows, because a grant requires credits>=BET.

Test Plan:
- Reset, then spin_req with reels ending 3,5,9 -> spin_go single pulse; credits 10->9; win_code=0; back to IDLE with credits=9; busy high throughout the play.
- Reels end 4,4,1 -> win_code=1; credits rise 9->11 over exactly 2 ticks; paying high for those ticks.
- Reels end 7,7,7 with credits=240 -> win_code=3; credits saturate at 255 after 15 ticks; PAYOUT lasts 50 ticks, then IDLE.
- credits=0, spin_req -> no spin_go, credits stay 0, no_credit=1, busy=0.
- reel_run drops to 000 for 1 cycle then returns high -> stays in SPIN; a later stable 000 -> EVAL.
- No reel_run activity after grant -> SPIN after 3 ticks, evaluated normally.
- CLR asserted mid-PAYOUT -> next cycle IDLE, credits=10, win_code=0.
- spin_req during SPIN -> ignored, no second deduction.

Source files
------------

// File: rtl/slot_payout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : slot_payout_ctrl                                                 |
// | Brief   : Credit-gated spin grant, reel-stop settle, win classification    |
// |           and tick-paced credit payout for a three-reel slot machine.      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module slot_payout_ctrl #(
    parameter int         CREDIT_W      = 8,
    parameter int         START_CREDITS = 10,
    parameter int         BET           = 1,
    parameter int         PAY_PAIR      = 2,
    parameter int         PAY_TRIPLE    = 10,
    parameter int         PAY_JACKPOT   = 50,
    parameter logic [3:0] JACKPOT_SYM   = 4'h7,
    parameter int         START_TMO     = 3,
    parameter int         SETTLE        = 2
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [3:0]          reel1,
    input  logic [3:0]          reel2,
    input  logic [3:0]          reel3,
    input  logic [2:0]          reel_run,
    input  logic                spin_req,
    input  logic                tick,
    output logic                spin_go,
    output logic [CREDIT_W-1:0] credits,
    output logic [1:0]          win_code,
    output logic                busy,
    output logic                paying,
    output logic                no_credit
);

    localparam int TMO_W = (START_TMO < 2) ? 1 : $clog2(START_TMO + 1);
    localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    localparam logic [CREDIT_W-1:0] C_START   = CREDIT_W'(START_CREDITS);
    localparam logic [CREDIT_W-1:0] C_BET     = CREDIT_W'(BET);
    localparam logic [CREDIT_W-1:0] C_PAY_P   = CREDIT_W'(PAY_PAIR);
    localparam logic [CREDIT_W-1:0] C_PAY_T   = CREDIT_W'(PAY_TRIPLE);
    localparam logic [CREDIT_W-1:0] C_PAY_J   = CREDIT_W'(PAY_JACKPOT);
    localparam logic [CREDIT_W-1:0] C_MAX     = {CREDIT_W{1'b1}};
    localparam logic [CREDIT_W-1:0] C_ONE     = CREDIT_W'(1);
    localparam logic [TMO_W-1:0]    C_TMO_END = TMO_W'(START_TMO);
    localparam logic [SET_W-1:0]    C_SET_END = SET_W'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_SPIN       = 3'd2,
        S_EVAL       = 3'd3,
        S_PAYOUT     = 3'd4
    } state_t;

    state_t              state_q,    state_d;
    logic [CREDIT_W-1:0] credits_q,  credits_d;
    logic [CREDIT_W-1:0] remain_q,   remain_d;
    logic [1:0]          win_code_q, win_code_d;
    logic                spin_go_q,  spin_go_d;
    logic [TMO_W-1:0]    tmo_q,      tmo_d;
    logic [SET_W-1:0]    settle_q,   settle_d;

    logic                w_triple;
    logic                w_pair;
    logic                w_jackpot;
    logic [TMO_W-1:0]    w_tmo_inc;
    logic [SET_W-1:0]    w_settle_inc;

    assign w_triple     = (reel1 == reel2) && (reel2 == reel3);
    assign w_pair       = (reel1 == reel2) || (reel2 == reel3) || (reel1 == reel3);
    assign w_jackpot    = w_triple && (reel1 == JACKPOT_SYM);
    assign w_tmo_inc    = tmo_q + TMO_W'(1);
    assign w_settle_inc = settle_q + SET_W'(1);

    always_comb begin
        state_d    = state_q;
        credits_d  = credits_q;
        remain_d   = remain_q;
        win_code_d = win_code_q;
        spin_go_d  = 1'b0;
        tmo_d      = tmo_q;
        settle_d   = settle_q;

        case (state_q)
            S_IDLE: begin
                if (spin_req && (credits_q >= C_BET)) begin
                    credits_d  = credits_q - C_BET;
                    spin_go_d  = 1'b1;
                    win_code_d = 2'd0;
                    tmo_d      = '0;
                    state_d    = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                // Timeout covers reels whose latched target already equals their position.
                if (reel_run != 3'b000) begin
                    settle_d = '0;
                    state_d  = S_SPIN;
                end else if (tick) begin
                    tmo_d = w_tmo_inc;
                    if (w_tmo_inc >= C_TMO_END) begin
                        settle_d = '0;
                        state_d  = S_SPIN;
                    end
                end
            end
            S_SPIN: begin
                if (reel_run == 3'b000) begin
                    settle_d = w_settle_inc;
                    if (w_settle_inc >= C_SET_END) begin
                        state_d = S_EVAL;
                    end
                end else begin
                    settle_d = '0;
                end
            end
            S_EVAL: begin
                if (w_jackpot) begin
                    win_code_d = 2'd3;
                    remain_d   = C_PAY_J;
                end else if (w_triple) begin
                    win_code_d = 2'd2;
                    remain_d   = C_PAY_T;
                end else if (w_pair) begin
                    win_code_d = 2'd1;
                    remain_d   = C_PAY_P;
                end else begin
                    win_code_d = 2'd0;
                    remain_d   = '0;
                end
                state_d = S_PAYOUT;
            end
            S_PAYOUT: begin
                // Countdown continues through saturation so excess credits are discarded.
                if (remain_q == '0) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    credits_d = (credits_q == C_MAX) ? credits_q : credits_q + C_ONE;
                    remain_d  = remain_q - C_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            credits_q  <= C_START;
            remain_q   <= '0;
            win_code_q <= 2'd0;
            spin_go_q  <= 1'b0;
            tmo_q      <= '0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            remain_q   <= remain_d;
            win_code_q <= win_code_d;
            spin_go_q  <= spin_go_d;
            tmo_q      <= tmo_d;
            settle_q   <= settle_d;
        end
    end

    assign spin_go   = spin_go_q;
    assign credits   = credits_q;
    assign win_code  = win_code_q;
    assign busy      = (state_q != S_IDLE);
    assign paying    = (state_q == S_PAYOUT);
    assign no_credit = (credits_q < C_BET);

endmodule
`default_nettype wire
